// File: rtl/carbon_mmio_hub.sv
// MMIO slave register block: byte-writable signature, sticky poweroff, buffered UART TX
// FIFO with overflow status, and a parametrised scratch bank behind a one-outstanding handshake.
module carbon_mmio_hub #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_F000,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ID_W            = 4,
    parameter logic [31:0] SIGNATURE_RESET = 32'h0,
    parameter int unsigned RESP_LATENCY    = 0,
    parameter int unsigned TX_FIFO_DEPTH   = 8,
    parameter int unsigned NUM_SCRATCH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    input  logic [ID_W-1:0]   req_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ID_W-1:0]   rsp_id,
    output logic [31:0]       signature,
    output logic              poweroff,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    output logic [7:0]        uart_tx_data
);

    localparam int unsigned PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_FIFO_DEPTH);
    localparam logic [2:0]       LAT_LOAD = 3'(RESP_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e              state_q, state_d;
    logic [2:0]          lat_q, lat_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [31:0]         sig_q, sig_d;
    logic                poweroff_q, poweroff_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          mem_q [TX_FIFO_DEPTH];
    logic [7:0]          mem_d [TX_FIFO_DEPTH];
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [31:0]         scratch_q [SCR_N];
    logic [31:0]         scratch_d [SCR_N];

    logic [5:0]  word_c;
    logic        accept_c, wr_en_c, hit_c;
    logic [31:0] rd_c;
    logic        full_c, empty_c, pop_c, push_req_c, push_c;
    logic        unused_c;

    assign unused_c = ^{req_addr[ADDR_W-1:8], req_addr[1:0], BASE_ADDR};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Decode, register side effects, FIFO bookkeeping and handshake FSM
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_id_d    = rsp_id_q;
        sig_d       = sig_q;
        poweroff_d  = poweroff_q;
        ovf_d       = ovf_q;
        scratch_d   = scratch_q;
        mem_d       = mem_q;
        hit_c       = 1'b0;
        rd_c        = 32'h0;
        push_req_c  = 1'b0;

        word_c   = req_addr[7:2];
        accept_c = (state_q == ST_IDLE) && req_valid;
        wr_en_c  = accept_c && req_write;
        full_c   = (count_q == DEPTH_C);
        empty_c  = (count_q == '0);
        pop_c    = tx_valid_q && uart_tx_ready;

        case (word_c)
            6'd0: begin
                hit_c = 1'b1;
                rd_c  = sig_q;
                if (wr_en_c) sig_d = merge_bytes(sig_q, req_wdata, req_wstrb);
            end
            6'd1: begin
                hit_c = 1'b1;
                rd_c  = {31'b0, poweroff_q};
                if (wr_en_c && req_wstrb[0] && req_wdata[0]) poweroff_d = 1'b1;
            end
            6'd2: begin
                hit_c      = 1'b1;
                push_req_c = wr_en_c && req_wstrb[0];
            end
            6'd3: begin
                hit_c = 1'b1;
                rd_c  = {16'b0, 8'(count_q), 5'b0, ovf_q, full_c, empty_c};
                if (wr_en_c && req_wstrb[0] && req_wdata[2]) ovf_d = 1'b0;
            end
            default: ;
        endcase

        for (int unsigned i = 0; i < SCR_N; i++) begin
            if (i < NUM_SCRATCH && {1'b0, word_c} == 7'(4 + i)) begin
                hit_c = 1'b1;
                rd_c  = scratch_q[i];
                if (wr_en_c) scratch_d[i] = merge_bytes(scratch_q[i], req_wdata, req_wstrb);
            end
        end

        // A full FIFO still takes the byte when the head leaves in the same cycle
        push_c = push_req_c && (!full_c || pop_c);
        if (push_req_c && !push_c) ovf_d = 1'b1;
        if (push_c) mem_d[wr_ptr_q] = req_wdata[7:0];

        wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        tx_valid_d = (count_d != '0);
        tx_data_d  = tx_valid_d ? mem_d[rd_ptr_d] : tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_id_d    = req_id;
                    rsp_err_d   = !hit_c;
                    rsp_rdata_d = (!req_write && hit_c) ? rd_c : 32'h0;
                    if (RESP_LATENCY > 0) begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_q == 3'd0) state_d = ST_RESP;
                else               lat_d   = lat_q - 3'd1;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_q       <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            sig_q       <= SIGNATURE_RESET;
            poweroff_q  <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h0;
            for (int i = 0; i < TX_FIFO_DEPTH; i++) mem_q[i] <= 8'h0;
            for (int i = 0; i < SCR_N; i++) scratch_q[i] <= 32'h0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_id_q    <= rsp_id_d;
            sig_q       <= sig_d;
            poweroff_q  <= poweroff_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_q       <= mem_d;
            scratch_q   <= scratch_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_id        = rsp_id_q;
    assign signature     = sig_q;
    assign poweroff      = poweroff_q;
    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;

endmodule

// File: tb/tb_carbon_mmio_hub.sv
// Bench for carbon_mmio_hub: three instances (latency 0/3/7) driven by directed steps
// plus random traffic, checked against a register-map model with a byte queue for the FIFO.
module tb_carbon_mmio_hub;

    localparam logic [31:0] SIG_RST = 32'h1234_5678;
    localparam int          NSCR    = 4;
    localparam int          DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst_n         [3];
    logic        req_valid     [3];
    logic        req_ready     [3];
    logic [31:0] req_addr      [3];
    logic        req_write     [3];
    logic [31:0] req_wdata     [3];
    logic [3:0]  req_wstrb     [3];
    logic [3:0]  req_id        [3];
    logic        rsp_valid     [3];
    logic        rsp_ready     [3];
    logic [31:0] rsp_rdata     [3];
    logic        rsp_err       [3];
    logic [3:0]  rsp_id        [3];
    logic [31:0] signature     [3];
    logic        poweroff      [3];
    logic        uart_tx_valid [3];
    logic        uart_tx_ready [3];
    logic [7:0]  uart_tx_data  [3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_sig [3];
    logic        m_po  [3];
    logic        m_ovf [3];
    logic [31:0] m_scr [3][NSCR];
    logic [7:0]  m_q   [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        carbon_mmio_hub #(
            .RESP_LATENCY   (g == 0 ? 0 : (g == 1 ? 3 : 7)),
            .SIGNATURE_RESET(SIG_RST)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_addr     (req_addr[g]),
            .req_write    (req_write[g]),
            .req_wdata    (req_wdata[g]),
            .req_wstrb    (req_wstrb[g]),
            .req_id       (req_id[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g]),
            .rsp_id       (rsp_id[g]),
            .signature    (signature[g]),
            .poweroff     (poweroff[g]),
            .uart_tx_valid(uart_tx_valid[g]),
            .uart_tx_ready(uart_tx_ready[g]),
            .uart_tx_data (uart_tx_data[g])
        );
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 7);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] st);
        logic [31:0] r = old_v;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Reference register map: returns expected read data/err from the pre-write state, then applies the write
    function automatic void mdl(input int k, input bit wr, input logic [7:0] off,
                                input logic [31:0] wd, input logic [3:0] st,
                                output logic [31:0] rd, output bit er);
        int w = int'(off[7:2]);
        rd = 32'h0;
        er = 1'b0;
        if (w == 0) begin
            if (wr) m_sig[k] = lanes(m_sig[k], wd, st); else rd = m_sig[k];
        end else if (w == 1) begin
            if (wr) begin if (st[0] && wd[0]) m_po[k] = 1'b1; end
            else rd = {31'b0, m_po[k]};
        end else if (w == 2) begin
            if (wr && st[0] && k == 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]); else m_ovf[k] = 1'b1;
            end
        end else if (w == 3) begin
            if (wr) begin if (st[0] && wd[2]) m_ovf[k] = 1'b0; end
            else rd = {16'b0, 8'(m_q.size()), 5'b0, m_ovf[k],
                       m_q.size() == DEPTH, m_q.size() == 0};
        end else if (w >= 4 && w < 4 + NSCR) begin
            if (wr) m_scr[k][w-4] = lanes(m_scr[k][w-4], wd, st); else rd = m_scr[k][w-4];
        end else begin
            er = 1'b1;
        end
    endfunction

    // One request/response with optional response stall; checks latency, fields and handshake
    task automatic txn(input int k, input bit wr, input logic [7:0] off, input logic [31:0] wd,
                       input logic [3:0] st, input int stall, input bit drop_rdy,
                       input logic [31:0] exp_rd, input bit exp_err);
        logic [3:0] id = 4'($urandom);
        int cnt = 0;
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = {16'h0000, 8'hF0, off};
        req_write[k] = wr;
        req_wdata[k] = wd;
        req_wstrb[k] = st;
        req_id[k]    = id;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        if (drop_rdy) uart_tx_ready[k] = 1'b0;
        while (rsp_valid[k] !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("rsp_latency", 32'(cnt), 32'(lat_of(k)));
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 32'(rsp_valid[k]), 32'd1);
            chk("stall_rdata", rsp_rdata[k], exp_rd);
            chk("stall_id", 32'(rsp_id[k]), 32'(id));
            @(posedge clk); #1;
        end
        chk("rsp_rdata", rsp_rdata[k], exp_rd);
        chk("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
        chk("rsp_id", 32'(rsp_id[k]), 32'(id));
        chk("req_ready_busy", 32'(req_ready[k]), 32'd0);
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        chk("rsp_valid_done", 32'(rsp_valid[k]), 32'd0);
    endtask

    task automatic op(input int k, input bit wr, input logic [7:0] off, input logic [31:0] wd,
                      input logic [3:0] st, input int stall, input bit drop_rdy);
        logic [31:0] r;
        bit e;
        mdl(k, wr, off, wd, st, r, e);
        txn(k, wr, off, wd, st, stall, drop_rdy, r, e);
    endtask

    task automatic drain();
        uart_tx_ready[0] = 1'b1;
        while (m_q.size() > 0) begin
            chk("drain_valid", 32'(uart_tx_valid[0]), 32'd1);
            chk("drain_data", 32'(uart_tx_data[0]), 32'(m_q.pop_front()));
            @(posedge clk); #1;
        end
        uart_tx_ready[0] = 1'b0;
        chk("drain_empty", 32'(uart_tx_valid[0]), 32'd0);
    endtask

    initial begin
        logic [7:0] off;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = '0; req_write[k] = 1'b0;
            req_wdata[k] = '0; req_wstrb[k] = '0; req_id[k] = '0; rsp_ready[k] = 1'b0;
            uart_tx_ready[k] = 1'b0;
            m_sig[k] = SIG_RST; m_po[k] = 1'b0; m_ovf[k] = 1'b0;
            for (int i = 0; i < NSCR; i++) m_scr[k][i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id[k]), 32'd0);
            chk("rst_signature", signature[k], SIG_RST);
            chk("rst_poweroff", 32'(poweroff[k]), 32'd0);
            chk("rst_tx_valid", 32'(uart_tx_valid[k]), 32'd0);
            chk("rst_tx_data", 32'(uart_tx_data[k]), 32'd0);
        end

        // Byte-lane signature writes
        op(0, 1, 8'h00, 32'h0000_005A, 4'b0001, 0, 0);
        op(0, 1, 8'h01, 32'h0000_3800, 4'b0010, 0, 0);
        op(0, 1, 8'h02, 32'h0030_0000, 4'b0100, 0, 0);
        op(0, 1, 8'h03, 32'h2100_0000, 4'b1000, 0, 0);
        chk("sig_bytes", signature[0], 32'h2130_385A);
        op(0, 0, 8'h00, 32'h0, 4'h0, 1, 0);

        // Sticky poweroff
        op(0, 1, 8'h04, 32'h1, 4'h1, 0, 0);
        chk("poweroff_set", 32'(poweroff[0]), 32'd1);
        op(0, 1, 8'h04, 32'h0, 4'h1, 0, 0);
        chk("poweroff_sticky", 32'(poweroff[0]), 32'd1);
        op(0, 0, 8'h04, 32'h0, 4'h0, 0, 0);

        // Overflow with a stalled sink, then clear and drain
        for (int i = 0; i < 9; i++) op(0, 1, 8'h08, 32'(8'h41 + i), 4'h1, 0, 0);
        op(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0);
        chk("status_full_ovf_model", {16'b0, 8'(m_q.size()), 5'b0, m_ovf[0], 2'b10}, 32'h0000_0806);
        op(0, 1, 8'h0C, 32'h4, 4'h1, 0, 0);
        op(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0);
        drain();
        op(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0);

        // Full FIFO: push in the same cycle as a pop
        for (int i = 0; i < 8; i++) op(0, 1, 8'h08, 32'(8'h60 + i), 4'h1, 0, 0);
        uart_tx_ready[0] = 1'b1;
        void'(m_q.pop_front());
        op(0, 1, 8'h08, 32'h0000_00EE, 4'h1, 0, 1);
        op(0, 0, 8'h0C, 32'h0, 4'h0, 0, 0);
        drain();

        // Unmapped offsets and the last scratch register
        op(0, 0, 8'hFC, 32'h0, 4'h0, 0, 0);
        op(0, 0, 8'(16 + 4 * NSCR), 32'h0, 4'h0, 0, 0);
        op(0, 1, 8'(16 + 4 * NSCR), 32'hFFFF_FFFF, 4'hF, 0, 0);
        op(0, 1, 8'(12 + 4 * NSCR), 32'hDEAD_BEEF, 4'hF, 0, 0);
        op(0, 0, 8'(12 + 4 * NSCR), 32'h0, 4'h0, 2, 0);
        chk("scratch_model", m_scr[0][NSCR-1], 32'hDEAD_BEEF);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: off = 8'h00;
                1: off = 8'h04;
                2: off = 8'h08;
                3: off = 8'h0C;
                4, 5, 6, 7: off = 8'(16 + 4 * $urandom_range(0, NSCR - 1));
                8: off = 8'(16 + 4 * NSCR);
                default: off = 8'($urandom_range(0, 255));
            endcase
            off[1:0] = 2'($urandom);
            op(0, 1'($urandom), off, $urandom, 4'($urandom), $urandom_range(0, 2), 0);
            chk("rnd_signature", signature[0], m_sig[0]);
            chk("rnd_poweroff", 32'(poweroff[0]), 32'(m_po[0]));
            chk("rnd_tx_valid", 32'(uart_tx_valid[0]), 32'(m_q.size() > 0));
            if (m_q.size() > 0) chk("rnd_tx_data", 32'(uart_tx_data[0]), 32'(m_q[0]));
        end

        // Latency sweep with stalled response
        for (int k = 0; k < 3; k++) begin
            op(k, 1, 8'h00, 32'hA5A5_0000 + 32'(k), 4'hF, 5, 0);
            op(k, 0, 8'h00, 32'h0, 4'h0, 5, 0);
            op(k, 1, 8'h10, 32'h0BAD_F00D, 4'b0101, 5, 0);
            op(k, 0, 8'h10, 32'h0, 4'h0, 5, 0);
        end

        // Reset while a response is pending in WAIT
        txn(2, 1, 8'h08, 32'h0000_0077, 4'h1, 0, 0, 32'h0, 1'b0);
        chk("k2_tx_valid", 32'(uart_tx_valid[2]), 32'd1);
        chk("k2_tx_data", 32'(uart_tx_data[2]), 32'h77);
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h0000_F000;
        req_write[2] = 1'b0;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("wait_req_ready", 32'(req_ready[2]), 32'd0);
        rst_n[2] = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready[2]), 32'd1);
        chk("mid_rst_signature", signature[2], SIG_RST);
        chk("mid_rst_tx_valid", 32'(uart_tx_valid[2]), 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        m_sig[2] = SIG_RST;
        m_po[2]  = 1'b0;
        for (int i = 0; i < NSCR; i++) m_scr[2][i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        op(2, 0, 8'h00, 32'h0, 4'h0, 0, 0);
        op(2, 0, 8'h10, 32'h0, 4'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
